irq_pend_arb: RTL

- Interrupt pending/arbitration stage that sits directly upstream of the team's 4-input priority encoder.
- Rising edges on each source are captured into sticky pending bits, which are masked and exported as the 4-bit request vector the encoder consumes.
- It also arbitrates internally, with the highest index winning, and presents one interrupt ID at a time to a consumer over a valid/ready handshake.
- A pending bit clears only when its ID is accepted.

---
 rtl/irq_pend_arb_pkg.sv | 19 +
 rtl/irq_pend_arb_if.sv | 15 +
 rtl/irq_pend_arb.sv | 106 ++++++++++
 3 files changed

// File: rtl/irq_pend_arb_pkg.sv
// rtl/irq_pend_arb_pkg.sv - shared constants, FSM states and priority helper for irq_pend_arb
// Purpose : common definitions imported by the interface and the pending/arbitration stage.
// Contents: N_SRC, ID_W, irq_state_e, hi_prio_idx().
package irq_pkg;

   localparam int N_SRC = 4;
   localparam int ID_W  = 2;

   typedef enum logic {IDLE, PRESENT} irq_state_e;

   // Same 3 > 2 > 1 > 0 ordering as the downstream priority encoder; 0 when nothing is set.
   function automatic logic [ID_W-1:0] hi_prio_idx(input logic [3:0] v);
      if (v[3])      return 2'd3;
      else if (v[2]) return 2'd2;
      else if (v[1]) return 2'd1;
      else           return 2'd0;
   endfunction

endpackage

// File: rtl/irq_pend_arb_if.sv
// rtl/irq_pend_arb_if.sv - valid/ready interrupt-ID handshake between arbiter and consumer
// Purpose : bundles the ID presentation handshake.
// Signals : irq_valid (ID presented), irq_id (presented ID), irq_ready (consumer accepts).
// Modports: master = arbiter side, slave = consumer side.
interface irq_if;
   import irq_pkg::*;

   logic            irq_valid;
   logic [ID_W-1:0] irq_id;
   logic            irq_ready;

   modport master (output irq_valid, output irq_id, input  irq_ready);
   modport slave  (input  irq_valid, input  irq_id, output irq_ready);

endinterface

// File: rtl/irq_pend_arb.sv
// rtl/irq_pend_arb.sv - rising-edge capture, sticky pending, lost flags and ID arbitration
// Purpose : captures source rising edges into sticky pending bits, exports the masked
//           pending vector for the priority encoder, and presents one ID at a time.
// Ports   : clk        - clock, all state on rising edge
//           rst_n      - synchronous active-low reset
//           irq_in     - level source lines (already synchronous)
//           irq_mask   - 1 = source enabled (gates arbitration and pend_vec, not capture)
//           lost_clr   - per-bit clear of lost_o
//           pend_vec   - registered pending & irq_mask
//           lost_o     - sticky: edge arrived while that source was already pending
//           irq        - irq_if.master handshake (irq_valid, irq_id, irq_ready)
module irq_pend_arb
   import irq_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_SRC-1:0] irq_in,
   input  logic [N_SRC-1:0] irq_mask,
   input  logic [N_SRC-1:0] lost_clr,
   output logic [N_SRC-1:0] pend_vec,
   output logic [N_SRC-1:0] lost_o,
   irq_if.master            irq
);

   logic [N_SRC-1:0] r_irq_q;
   logic [N_SRC-1:0] r_pending;
   logic [N_SRC-1:0] r_pend_vec;
   logic [N_SRC-1:0] r_lost;
   irq_state_e       r_state;
   logic             r_valid;
   logic [ID_W-1:0]  r_id;

   logic [N_SRC-1:0] w_rise;
   logic             w_acc;
   logic [N_SRC-1:0] w_clr;
   logic [N_SRC-1:0] w_pend_nxt;
   logic [N_SRC-1:0] w_lost_set;
   logic [N_SRC-1:0] w_eligible;
   irq_state_e       w_state_nxt;
   logic             w_valid_nxt;
   logic [ID_W-1:0]  w_id_nxt;

   assign w_rise     = irq_in & ~r_irq_q;
   assign w_acc      = r_valid & irq.irq_ready;
   assign w_clr      = w_acc ? (N_SRC'(1) << r_id) : '0;
   // A rise on a bit being cleared this cycle re-arms it, so the set term is OR'd last.
   assign w_pend_nxt = (r_pending & ~w_clr) | w_rise;
   assign w_lost_set = w_rise & r_pending & ~w_clr;
   assign w_eligible = r_pending & irq_mask;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // All-ones so a line held high across reset release is not seen as an edge.
         r_irq_q    <= '1;
         r_pending  <= '0;
         r_pend_vec <= '0;
         r_lost     <= '0;
      end else begin
         r_irq_q    <= irq_in;
         r_pending  <= w_pend_nxt;
         r_pend_vec <= w_pend_nxt & irq_mask;
         r_lost     <= w_lost_set | (r_lost & ~lost_clr);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_valid <= 1'b0;
         r_id    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_valid <= w_valid_nxt;
         r_id    <= w_id_nxt;
      end
   end

   // Arbitration looks only in IDLE, so the ID is frozen while presented and every
   // accept is followed by one IDLE cycle with irq_valid low.
   always_comb begin
      w_state_nxt = r_state;
      w_valid_nxt = r_valid;
      w_id_nxt    = r_id;
      case (r_state)
         IDLE: begin
            if (|w_eligible) begin
               w_id_nxt    = hi_prio_idx(w_eligible);
               w_valid_nxt = 1'b1;
               w_state_nxt = PRESENT;
            end
         end
         PRESENT: begin
            if (w_acc) begin
               w_valid_nxt = 1'b0;
               w_state_nxt = IDLE;
            end
         end
      endcase
   end

   assign pend_vec      = r_pend_vec;
   assign lost_o        = r_lost;
   assign irq.irq_valid = r_valid;
   assign irq.irq_id    = r_id;

endmodule
